v60_mem_responder: RTL

//   Memory-side responder for the v60_cpu memory bus (mem_req/mem_wr/mem_size/mem_addr/mem_wdata ->
//   mem_rdata/mem_ready). Backs the bus with an internal word-organised RAM, inserts programmable

---
 rtl/v60_mem_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/v60_mem_responder.sv
// Memory-side responder for the v60_cpu bus: word RAM, programmable wait states,
// little-endian byte/halfword lanes, illegal-access flagging and a word preload port.
`timescale 1ns/1ps
module v60_mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  bus_err,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [1:0]            dbg_state
);
    localparam int                    IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(MEM_WORDS * 4);
    localparam logic [3:0]            WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    capture;
    logic                    wr_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [31:0]             mem_q [MEM_WORDS];

    // In IDLE the live bus is the transaction being accepted; afterwards the latched copy is.
    logic                    eff_wr;
    logic [1:0]              eff_size;
    logic [ADDR_WIDTH-1:0]   eff_addr;
    logic [DATA_WIDTH-1:0]   eff_wdata;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        idx;
    logic                    acc_err;
    logic [31:0]             rd_word, rd_lane, wr_lane;
    logic [3:0]              be;
    logic                    wr_commit;
    logic [ADDR_WIDTH-1:0]   ld_off;
    logic                    ld_hit;

    assign eff_wr    = (state_q == S_IDLE) ? mem_wr    : wr_q;
    assign eff_size  = (state_q == S_IDLE) ? mem_size  : size_q;
    assign eff_addr  = (state_q == S_IDLE) ? mem_addr  : addr_q;
    assign eff_wdata = (state_q == S_IDLE) ? mem_wdata : wdata_q;
    assign offset    = eff_addr - BASE_ADDR;
    assign idx       = offset[IDX_W+1:2];
    assign rd_word   = mem_q[idx];

    always_comb begin
        acc_err = 1'b0;
        case (eff_size)
            2'b01:   acc_err = eff_addr[0];
            2'b10:   acc_err = (eff_addr[1:0] != 2'b00);
            2'b11:   acc_err = 1'b1;
            default: acc_err = 1'b0;
        endcase
        if (eff_addr < BASE_ADDR) acc_err = 1'b1;
        if (offset >= SPAN)       acc_err = 1'b1;
    end

    always_comb begin
        be      = 4'b0000;
        wr_lane = '0;
        rd_lane = '0;
        case (eff_size)
            2'b00: begin
                be      = 4'b0001 << eff_addr[1:0];
                wr_lane = {4{eff_wdata[7:0]}};
                case (eff_addr[1:0])
                    2'd0:    rd_lane = {24'h0, rd_word[7:0]};
                    2'd1:    rd_lane = {24'h0, rd_word[15:8]};
                    2'd2:    rd_lane = {24'h0, rd_word[23:16]};
                    default: rd_lane = {24'h0, rd_word[31:24]};
                endcase
            end
            2'b01: begin
                be      = eff_addr[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{eff_wdata[15:0]}};
                rd_lane = {16'h0, (eff_addr[1] ? rd_word[31:16] : rd_word[15:0])};
            end
            2'b10: begin
                be      = 4'b1111;
                wr_lane = eff_wdata;
                rd_lane = rd_word;
            end
            default: ;
        endcase
    end

    // State register plus registered outputs and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                wr_q    <= mem_wr;
                size_q  <= mem_size;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    capture = 1'b1;
                    cnt_d   = WS;
                    state_d = (WS != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response is computed on the edge that enters RESP so it appears during RESP.
    always_comb begin
        ready_d = (state_d == S_RESP);
        err_d   = ready_d && acc_err;
        rdata_d = (ready_d && !acc_err && !eff_wr) ? rd_lane : '0;
    end

    assign wr_commit = (state_q == S_RESP) && wr_q && !acc_err;
    assign ld_off    = ld_addr - BASE_ADDR;
    assign ld_hit    = ld_en && (ld_addr >= BASE_ADDR) && (ld_off < SPAN);

    // Preload first, bus write second: bus-written bytes override on a shared word.
    always_ff @(posedge clk) begin
        if (ld_hit) mem_q[ld_off[IDX_W+1:2]] <= ld_data;
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wr_lane[8*b +: 8];
            end
        end
    end

    assign mem_ready = ready_q;
    assign bus_err   = err_q;
    assign mem_rdata = rdata_q;
    assign dbg_state = state_q;
endmodule
